// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start + DATA_W data bits (LSB first) + parity + stop,
// sampled on bit_en strobes, reporting word, parity error and framing error.
module serial_parity_rx #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              par_err,
  output logic              frm_err,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   shift_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                acc_r;
  logic                perr_r;
  logic [DATA_W-1:0]   data_r;
  logic                valid_r;
  logic                par_err_r;
  logic                frm_err_r;

  // Nonzero when the running XOR of data bits plus the parity bit disagrees with the parity sense.
  function automatic logic parity_mismatch(input logic acc, input logic par_bit);
    return acc ^ par_bit ^ PARITY_ODD;
  endfunction

  // Frame FSM, datapath and registered result outputs; everything advances only on bit_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      shift_r   <= '0;
      cnt_r     <= '0;
      acc_r     <= 1'b0;
      perr_r    <= 1'b0;
      data_r    <= '0;
      valid_r   <= 1'b0;
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (bit_en) begin
        case (state_r)
          S_IDLE: begin
            if (!rx) begin
              state_r <= S_DATA;
              cnt_r   <= '0;
              acc_r   <= 1'b0;
            end
          end
          S_DATA: begin
            shift_r <= {rx, shift_r[DATA_W-1:1]};
            acc_r   <= acc_r ^ rx;
            // Counter saturates at the last data bit rather than wrapping.
            if (cnt_r == CNT_MAX) begin
              state_r <= S_PAR;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          S_PAR: begin
            perr_r  <= parity_mismatch(acc_r, rx);
            state_r <= S_STOP;
          end
          S_STOP: begin
            // A low stop bit is only a framing error; it is never taken as the next start.
            data_r    <= shift_r;
            par_err_r <= perr_r;
            frm_err_r <= ~rx;
            valid_r   <= 1'b1;
            state_r   <= S_IDLE;
          end
          default: begin
            state_r <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign data    = data_r;
  assign valid   = valid_r;
  assign par_err = par_err_r;
  assign frm_err = frm_err_r;
  assign busy    = (state_r != S_IDLE);

endmodule

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
- Serial frame receiver. Checks parity with an XOR reduction.
- Receiving end of the team's XOR-based parity generator/serial link: deserialises start + DATA_W data bits (LSB first) + parity bit + stop bit.
- Reports the word, a parity-error flag and a framing-error flag.
- Sits between a bit-timing tick source and downstream logic.

Parameters:
DATA_W, 8, number of data bits per frame (legal range 2..16)
PARITY_ODD, 0, 0 = even parity (XOR of data and parity bit must be 0); 1 = odd parity (XOR must be 1)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
bit_en  input  1  bit-time strobe; rx is sampled only on clk edges where bit_en=1
rx  input  1  serial line, idle high
data  output  DATA_W  last received word, LSB = first data bit
valid  output  1  one-cycle pulse: frame completed, data/par_err/frm_err updated
par_err  output  1  parity mismatch on last frame; held until the next frame completes
frm_err  output  1  stop bit sampled 0 on last frame; held until the next frame completes
busy  output  1  high while state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, shift register=0, bit counter=0, accumulator=0, data=0, valid=0, par_err=0, frm_err=0, busy=0. Released synchronously in effect: the first bit_en after deassertion is evaluated normally.
- FSM states: IDLE, DATA, PAR, STOP. Transitions occur only on edges where bit_en=1. With bit_en=0, all state holds and valid is forced to 0.
- IDLE:
  - rx=0 -> DATA; counter=0; acc=0.
  - rx=1 -> stay in IDLE.
- DATA:
  - shift reg <= {rx, shift[DATA_W-1:1]} (LSB first); acc <= acc ^ rx; counter++.
  - When counter reaches DATA_W-1 on this sample -> PAR.
- PAR: perr <= acc ^ rx ^ PARITY_ODD; -> STOP.
- STOP, on the stop sample:
  - data <= shift reg; par_err <= perr; frm_err <= ~rx; valid <= 1 for exactly one clk; -> IDLE.
  - data is delivered even when frm_err=1.
  - Latency: valid is high in the clk cycle following the stop-bit sampling edge.
- Back-to-back frames:
  - A start bit (rx=0) on the bit_en immediately after STOP is accepted.
  - valid may coincide with the first idle/start evaluation.
- Framing error with rx=0 at stop: return to IDLE. That same 0 is NOT reinterpreted as a start bit; the next bit_en with rx=0 starts a frame.
- rx changes between bit_en strobes are ignored. No oversampling and no glitch filtering.
- Reset mid-frame: the frame is abandoned immediately. data, par_err and frm_err return to 0, and no valid is issued.
- Counter width: $clog2(DATA_W); no wrap beyond DATA_W-1.
- busy is a combinational decode of state.

Test Plan:
- Even parity, DATA_W=8, frame 0,1,0,1,0,0,1,0,1 (data 0xA5 LSB first), parity 0, stop 1 -> one valid pulse; data=0xA5, par_err=0, frm_err=0, busy low after.
- Data 0x01, parity bit 0, stop 1 -> valid; data=0x01, par_err=1. Repeat with parity bit 1 -> par_err=0. Repeat with PARITY_ODD=1 and parity bit 0 -> par_err=0.
- Data 0x3C, correct parity 0, stop bit 0 -> valid; data=0x3C, frm_err=1. The following bit_en with rx=0 starts a new frame; the next good frame clears frm_err.
- bit_en asserted every 4th clk with rx toggling on off-strobe cycles -> only strobe-edge values are captured; data matches the strobe samples; valid width = 1 clk.
- Assert rst_n=0 after 4 data bits of 0xFF -> all outputs 0 asynchronously with no valid. A full frame 0x0F, parity 0 after release -> data=0x0F, par_err=0.
- Two back-to-back frames 0x81 then 0x7E (parity 0 each) with no idle bit between -> two valid pulses 11 strobes apart; data=0x81, then 0x7E.
